// File: rtl/div_32_seq_if.sv
// Start/done handshake and operand/result bundle between the control unit and div_32_seq.
// The master drives operands and start; the slave (divider) returns status and results.
interface div_32_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div_32_seq.sv
// Restoring sequential divider: one trial subtraction (add of ~D with carry-in 1) per clock.
// Define DIV_SIGNED_EN for two's-complement operands with truncation toward zero.
module div_32_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic         clk,
  input logic         clr_n,
  div_32_seq_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;      // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] p_q, p_d;      // partial remainder
  logic [WIDTH-1:0] d_q, d_d;      // captured divisor magnitude
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             div_zero_q, div_zero_d;

  logic             capture;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;
  logic             trial_ok;
  logic [WIDTH-1:0] step_p, step_a;
  logic [WIDTH-1:0] fin_quot, fin_rem;

  // A new operation is accepted from IDLE and from the DONE cycle, never while running.
  assign capture = bus.start && (state_q != RUN);

  // Trial subtraction as an adder: shifted + ~D + 1; carry out set means no borrow.
  assign shifted  = {p_q[WIDTH-2:0], a_q[WIDTH-1]};
  assign trial    = {1'b0, shifted} + {1'b0, ~d_q} + (WIDTH+1)'(1);
  assign trial_ok = trial[WIDTH];
  assign step_p   = trial_ok ? trial[WIDTH-1:0] : shifted;
  assign step_a   = {a_q[WIDTH-2:0], trial_ok};

`ifdef DIV_SIGNED_EN
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;
  logic dvd_neg, dvs_neg;

  assign dvd_neg = bus.dividend[WIDTH-1];
  assign dvs_neg = bus.divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
  assign dvs_mag = dvs_neg ? (~bus.divisor + WIDTH'(1)) : bus.divisor;

  always_comb begin
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    if (capture) begin
      neg_quot_d = dvd_neg ^ dvs_neg;
      neg_rem_d  = dvd_neg;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

  // A zero divisor keeps the all-ones quotient; restoring the remainder sign returns the dividend.
  assign fin_quot = (neg_quot_q && (d_q != '0)) ? (~step_a + WIDTH'(1)) : step_a;
  assign fin_rem  = neg_rem_q ? (~step_p + WIDTH'(1)) : step_p;
`else
  assign dvd_mag  = bus.dividend;
  assign dvs_mag  = bus.divisor;
  assign fin_quot = step_a;
  assign fin_rem  = step_p;
`endif

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    p_d        = p_q;
    d_d        = d_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE, DONE: begin
        if (capture) begin
          a_d     = dvd_mag;
          d_d     = dvs_mag;
          p_d     = '0;
          cnt_d   = CNT_LOAD;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = step_a;
        p_d   = step_p;
        cnt_d = cnt_q - CNT_ONE;
        // Last step: publish results in the same edge so done follows with fixed latency.
        if (cnt_q == CNT_ONE) begin
          quot_d     = fin_quot;
          rem_d      = fin_rem;
          div_zero_d = (d_q == '0);
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      p_q        <= '0;
      d_q        <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      p_q        <= p_d;
      d_q        <= d_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: doc/div_32_seq.md
Name: div_32_seq

Overview:
- Multi-cycle 32-bit divider in the ALU datapath, alongside the add_32 adder.
- Its subtract/restore step is the same 32-bit add with inverted operand and carry-in 1; it iterates that step once per clock.
- Consumes operands from the Y register and the bus; produces quotient (to Z LO) and remainder (to Z HI).
- Control unit drives it with a start/done handshake.

Parameters:
- WIDTH, 32, operand/quotient/remainder width
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
- clk  input  1  system clock, rising-edge
- clr_n  input  1  asynchronous active-low reset
- start  input  1  request a division; sampled at rising edge
- dividend  input  WIDTH  dividend (Y register); captured when start is accepted
- divisor  input  WIDTH  divisor (bus); captured when start is accepted
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle completion pulse
- quotient  output  WIDTH  result, to Z LO
- remainder  output  WIDTH  result, to Z HI
- div_zero  output  1  divisor was zero for the last completed operation

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset (clr_n=0, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_zero=0, counter=0.
  - Reset mid-operation aborts the operation; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: capture operands, clear partial remainder, counter=WIDTH, go to RUN, busy=1.
- RUN: one restoring step per edge.
  - Trial = {P[WIDTH-2:0], A[WIDTH-1]} - D, computed as WIDTH+1-bit add with ~D and cin=1.
  - Trial non-negative (carry out 1): P=trial, shift 1 into A.
  - Otherwise: P={P[WIDTH-2:0], A[WIDTH-1]}, shift 0 into A.
  - Counter decrements each step.
  - Edges k+1..k+WIDTH perform the WIDTH steps.
  - At edge k+WIDTH: quotient<=A, remainder<=P, div_zero<=(D==0), go to DONE, busy=0, done=1.
- Latency: done is high in the cycle after edge k+WIDTH (33 cycles after the start edge at default).
- DONE: lasts one cycle, done=1.
  - start=1: behaves as in IDLE (back-to-back accepted).
  - Otherwise go to IDLE, done=0.
- start while busy=1 is ignored; operand inputs are don't-care after capture.
- quotient/remainder/div_zero hold their values until the next completion or reset.
- Divide by zero: no special datapath; same fixed latency. The algorithm naturally yields quotient=all-ones and remainder=dividend; div_zero=1.
- No wrap/overflow on unsigned path; the counter never underflows (RUN exits when it reaches 0).

Optional Feature:
- Macro: DIV_SIGNED_EN
- Defined (two's-complement operands):
  - Absolute values are taken at capture.
  - Quotient is negated if operand signs differ; remainder takes the sign of the dividend (truncation toward zero).
  - Sign fix-up is applied at the DONE transition; latency is unchanged.
  - Most-negative / -1 returns quotient=0x80000000, remainder=0.
  - Divide by zero returns the raw unsigned results (quotient=all-ones, remainder=dividend), div_zero=1.
- Not defined: unsigned only; no sign logic synthesised.

Test Plan:
- Reset, then start with dividend=100, divisor=7 -> done 33 cycles later; quotient=14, remainder=2, div_zero=0; busy high 32 cycles.
- Unsigned: dividend=0xFFFFFFFF, divisor=10 -> quotient=0x19999999, remainder=5.
- Divisor=0, dividend=0x12345678 -> quotient=0xFFFFFFFF, remainder=0x12345678, div_zero=1, same 33-cycle latency.
- start pulsed mid-RUN with new operands -> ignored; first result 100/7 returned, no second done.
  - start held in the DONE cycle with 20/3 -> next result quotient=6, remainder=2.
- clr_n low for 1 cycle at step 10 of a division -> all outputs 0 immediately, state IDLE, no done pulse; a fresh 9/3 afterwards gives 3 r 0.
- With DIV_SIGNED_EN: -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
